arb_loader: RTL and testbench

- Producer side of the 64-way score/position arbiter interface. It collects candidate (score, position) pairs from the move generator over a valid/ready stream and packs them into a 64-slot register bank.
- The bank is presented as flattened buses that drive the arbiter's in1..in64 and inpos_1..inpos_64 inputs.
- It holds the bank stable, with frame_valid high, until the downstream consumer acknowledges the arbiter's winning result.

---
 rtl/arb_loader.sv | 96 +++++++++
 tb/tb_arb_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_loader.sv
// Loader that packs (score, position) beats into the 64-slot arbiter bank
// and holds it stable with frame_valid until the result is acknowledged.
module arb_loader #(
  parameter int N_SLOTS = 64,
  parameter int W       = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_score,
  input  logic [W-1:0]         in_pos,
  input  logic                 in_last,
  output logic [N_SLOTS*W-1:0] scores_flat,
  output logic [N_SLOTS*W-1:0] pos_flat,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [6:0]           count,
  output logic                 truncated
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(N_SLOTS - 1);

  state_t state, state_nxt;

  logic [W-1:0] score_q [N_SLOTS];
  logic [W-1:0] pos_q   [N_SLOTS];
  logic [6:0]   count_q;
  logic         trunc_q;
  logic         accept;
  logic         at_last;

  assign accept  = (state == LOAD) && in_valid && !start;
  assign at_last = (count_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    if (accept && (in_last || at_last)) state_nxt = PRESENT;
        PRESENT: if (frame_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Cleared slots read as score 0, which the arbiter treats as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        score_q[k] <= '0;
        pos_q[k]   <= '0;
      end
      count_q <= '0;
      trunc_q <= 1'b0;
    end else if (start) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        score_q[k] <= '0;
        pos_q[k]   <= '0;
      end
      count_q <= '0;
      trunc_q <= 1'b0;
    end else if (accept) begin
      score_q[count_q[5:0]] <= in_score;
      pos_q[count_q[5:0]]   <= in_pos;
      count_q               <= count_q + 7'd1;
      if (at_last && !in_last) trunc_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_flat
    assign scores_flat[W*k +: W] = score_q[k];
    assign pos_flat[W*k +: W]    = pos_q[k];
  end

  assign in_ready    = (state == LOAD);
  assign frame_valid = (state == PRESENT);
  assign count       = count_q;
  assign truncated   = trunc_q;

endmodule

// File: tb/tb_arb_loader.sv
// Directed bench for arb_loader: vector table for the basic frame,
// hand sequences for full frame, restart, start+ack and async reset.
module tb_arb_loader;

  localparam int N  = 64;
  localparam int W  = 6;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          frame_ack = 1'b0;
  logic [W-1:0]  in_score = '0;
  logic [W-1:0]  in_pos = '0;
  logic          in_ready;
  logic          frame_valid;
  logic          truncated;
  logic [6:0]    count;
  logic [FW-1:0] scores_flat;
  logic [FW-1:0] pos_flat;

  arb_loader #(.N_SLOTS(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_score   (in_score),
    .in_pos     (in_pos),
    .in_last    (in_last),
    .scores_flat(scores_flat),
    .pos_flat   (pos_flat),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .count      (count),
    .truncated  (truncated)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] es [N];
  logic [W-1:0] ep [N];

  typedef struct {
    logic       st;
    logic       v;
    logic [5:0] s;
    logic [5:0] p;
    logic       l;
    logic       a;
    logic [6:0] c;
    logic       fv;
    logic       rdy;
    logic       tr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic st, logic v, logic [5:0] s,
                              logic [5:0] p, logic l, logic a,
                              logic [6:0] c, logic fv, logic rdy,
                              logic tr);
    vec_t r;
    r.st = st; r.v = v; r.s = s; r.p = p; r.l = l; r.a = a;
    r.c = c; r.fv = fv; r.rdy = rdy; r.tr = tr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      es[k] = '0;
      ep[k] = '0;
    end
  endtask

  task automatic chk_bank(input string tag);
    logic [FW-1:0] xs;
    logic [FW-1:0] xp;
    for (int k = 0; k < N; k++) begin
      xs[W*k +: W] = es[k];
      xp[W*k +: W] = ep[k];
    end
    chk({tag, ".scores"}, scores_flat, xs);
    chk({tag, ".pos"}, pos_flat, xp);
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] c,
                         input logic fv, input logic rdy,
                         input logic tr);
    chk({tag, ".count"}, FW'(count), FW'(c));
    chk({tag, ".frame_valid"}, FW'(frame_valid), FW'(fv));
    chk({tag, ".in_ready"}, FW'(in_ready), FW'(rdy));
    chk({tag, ".truncated"}, FW'(truncated), FW'(tr));
  endtask

  task automatic drive(input logic st, input logic v,
                       input logic [5:0] s, input logic [5:0] p,
                       input logic l, input logic a);
    @(negedge clk);
    start = st; in_valid = v; in_score = s;
    in_pos = p; in_last = l; frame_ack = a;
    @(posedge clk);
    #1;
  endtask

  // Behavioural arbiter: highest score, lowest slot on ties.
  task automatic arb(output logic [5:0] o, output logic [5:0] op);
    o = '0;
    op = '0;
    for (int k = 0; k < N; k++) begin
      if (scores_flat[W*k +: W] > o) begin
        o  = scores_flat[W*k +: W];
        op = pos_flat[W*k +: W];
      end
    end
  endtask

  initial begin
    logic [5:0] ao;
    logic [5:0] aop;
    clear_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctl("init", 7'd0, 1'b0, 1'b0, 1'b0);
    chk_bank("init");

    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32, 33, 0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 5, 2, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 17, 3, 1, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 63, 63, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].s, tbl[i].p,
            tbl[i].l, tbl[i].a);
      chk_ctl($sformatf("row%0d", i), tbl[i].c, tbl[i].fv,
              tbl[i].rdy, tbl[i].tr);
    end

    es[0] = 6'd32; ep[0] = 6'd33;
    es[1] = 6'd5;  ep[1] = 6'd2;
    es[2] = 6'd17; ep[2] = 6'd3;
    chk_bank("basic");
    arb(ao, aop);
    chk("arb.out", FW'(ao), FW'(6'b100000));
    chk("arb.out_pos", FW'(aop), FW'(6'b100001));

    drive(0, 0, 0, 0, 0, 1);
    chk_ctl("ack", 7'd3, 1'b0, 1'b0, 1'b0);
    chk_bank("ack");

    drive(1, 0, 0, 0, 0, 0);
    clear_model();
    chk_ctl("full.start", 7'd0, 1'b0, 1'b1, 1'b0);
    chk_bank("full.start");
    for (int k = 0; k < N; k++) begin
      drive(0, 1, 6'(k + 1), 6'(k), 0, 0);
      es[k] = 6'(k + 1);
      ep[k] = 6'(k);
      if (k == N - 2) chk_ctl("full.63", 7'd63, 1'b0, 1'b1, 1'b0);
    end
    chk_ctl("full.64", 7'd64, 1'b1, 1'b0, 1'b1);
    drive(0, 1, 7, 7, 1, 0);
    chk_ctl("full.65th", 7'd64, 1'b1, 1'b0, 1'b1);
    chk_bank("full");
    drive(0, 0, 0, 0, 0, 1);
    chk_ctl("full.ack", 7'd64, 1'b0, 1'b0, 1'b1);
    chk_bank("full.ack");

    drive(1, 0, 0, 0, 0, 0);
    clear_model();
    for (int k = 0; k < 10; k++)
      drive(0, 1, 6'(k + 10), 6'(k), 0, 0);
    chk_ctl("rs.10", 7'd10, 1'b0, 1'b1, 1'b0);
    drive(1, 1, 50, 50, 1, 0);
    chk_ctl("rs.start", 7'd0, 1'b0, 1'b1, 1'b0);
    chk_bank("rs.start");
    drive(0, 1, 9, 9, 1, 0);
    es[0] = 6'd9; ep[0] = 6'd9;
    chk_ctl("rs.beat", 7'd1, 1'b1, 1'b0, 1'b0);
    chk_bank("rs.beat");

    drive(1, 0, 0, 0, 0, 1);
    clear_model();
    chk_ctl("sim", 7'd0, 1'b0, 1'b1, 1'b0);
    chk_bank("sim");

    drive(0, 1, 20, 21, 0, 0);
    es[0] = 6'd20; ep[0] = 6'd21;
    chk_ctl("pre.rst", 7'd1, 1'b0, 1'b1, 1'b0);
    chk_bank("pre.rst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    chk_ctl("arst", 7'd0, 1'b0, 1'b0, 1'b0);
    chk_bank("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
